// File: rtl/agc_mem_pkg.sv
// agc_mem_pkg: sequencer state encoding, bank-register addresses, and the
// logical-to-physical address translation used by agc_mem_sequencer.
package agc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } seq_state_t;

    localparam logic [11:0] EB_ADDR = 12'o3;
    localparam logic [11:0] FB_ADDR = 12'o4;
    localparam logic [11:0] BB_ADDR = 12'o6;
    localparam logic [11:0] SB_ADDR = 12'o7;

    // 12-bit logical address to 16-bit physical address using the current banks
    function automatic logic [15:0] agc_translate(
        input logic [2:0]  eb,
        input logic [4:0]  fb,
        input logic        sb,
        input logic [11:0] addr
    );
        logic [15:0] phys;
        if (addr[11]) begin
            phys = {4'b0, addr};
        end else if (!addr[10]) begin
            if (addr[9:8] == 2'b11) phys = {5'b0, eb, addr[7:0]};
            else                    phys = {6'b0, addr[9:0]};
        end else if ((fb[4:3] == 2'b11) && sb) begin
            phys = {3'b100, fb[2:0], addr[9:0]};
        end else begin
            phys = {1'b0, fb, addr[9:0]};
        end
        return phys;
    endfunction

    function automatic logic is_bank_addr(input logic [11:0] addr);
        return (addr == EB_ADDR) || (addr == FB_ADDR) ||
               (addr == BB_ADDR) || (addr == SB_ADDR);
    endfunction

    // Bank readback keeps each field in the bit positions used for writing
    function automatic logic [15:0] bank_read(
        input logic [2:0]  eb,
        input logic [4:0]  fb,
        input logic        sb,
        input logic [11:0] addr
    );
        logic [15:0] val;
        val = 16'h0000;
        case (addr)
            EB_ADDR: val = {5'b0, eb, 8'b0};
            FB_ADDR: val = {1'b0, fb, 10'b0};
            BB_ADDR: val = {1'b0, fb, 7'b0, eb};
            SB_ADDR: val = {9'b0, sb, 6'b0};
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/agc_rr_arb.sv
// agc_rr_arb: two-way CPU/counter arbiter. Round-robin by default; with
// CTR_FIXED_PRI=1 the counter unit always wins contention.
module agc_rr_arb #(
    parameter int CTR_FIXED_PRI = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic ctr_req,
    input  logic grant_en,
    output logic grant_cpu,
    output logic grant_ctr
);

    logic prio_ctr;

    // Pick a winner from the current requests and the round-robin pointer
    always_comb begin
        grant_cpu = 1'b0;
        grant_ctr = 1'b0;
        if (cpu_req && ctr_req) begin
            if ((CTR_FIXED_PRI != 0) || prio_ctr) grant_ctr = 1'b1;
            else                                  grant_cpu = 1'b1;
        end else begin
            grant_cpu = cpu_req;
            grant_ctr = ctr_req;
        end
    end

    // Pointer moves only when a grant is actually taken; the loser is favoured next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ctr <= 1'b0;
        end else if (grant_en && (grant_cpu || grant_ctr)) begin
            prio_ctr <= grant_cpu;
        end
    end

endmodule

// File: rtl/agc_mem_sequencer.sv
// agc_mem_sequencer: owns EB/FB/superbank and shares the memory port between
// the CPU and the counter unit, translating logical to physical addresses.
// Build option FIXED_WRITE_PROTECT_EN: writes with addr[11:10] != 00 are
// refused (no memory cycle) and acknowledged with err.
//
// state  | meaning
// IDLE   | waiting; samples requests and latches the winner's request
// GRANT  | translates the address; bank-register accesses complete here
// ACCESS | memory cycle active, abort timer running
// RESP   | one-cycle ack (with err on abort or refusal) to the owner
module agc_mem_sequencer
    import agc_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC   = 15,
    parameter int          CTR_FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        ctr_req,
    input  logic        ctr_we,
    input  logic [11:0] ctr_addr,
    input  logic [15:0] ctr_wdata,
    output logic        ctr_ack,
    output logic [15:0] ctr_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [2:0]  eb_q,
    output logic [4:0]  fb_q,
    output logic        sb_q,
    output logic        err
);

    localparam logic [7:0] TMO_LOAD = TIMEOUT_CYC[7:0];

    seq_state_t  state, state_nxt;
    logic        grant_cpu, grant_ctr;
    logic        sample;
    logic        owner_ctr;
    logic        we_lat;
    logic [11:0] addr_lat;
    logic [2:0]  eb;
    logic [4:0]  fb;
    logic        sb;
    logic [7:0]  tmr;
    logic        err_flag;
    logic        bank_hit;
    logic        prot_hit;
    logic        load_rdata;
    logic        set_err;
    logic [15:0] resp_data;

    agc_rr_arb #(
        .CTR_FIXED_PRI(CTR_FIXED_PRI)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .ctr_req  (ctr_req),
        .grant_en (sample),
        .grant_cpu(grant_cpu),
        .grant_ctr(grant_ctr)
    );

    assign bank_hit = is_bank_addr(addr_lat);

`ifdef FIXED_WRITE_PROTECT_EN
    assign prot_hit = we_lat && (addr_lat[11:10] != 2'b00);
`else
    assign prot_hit = 1'b0;
`endif

    assign mem_en  = (state == ST_ACCESS);
    assign mem_we  = (state == ST_ACCESS) && we_lat;
    assign cpu_ack = (state == ST_RESP) && !owner_ctr;
    assign ctr_ack = (state == ST_RESP) && owner_ctr;
    assign err     = (state == ST_RESP) && err_flag;
    assign eb_q    = eb;
    assign fb_q    = fb;
    assign sb_q    = sb;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state plus the response data/err decisions taken on leaving GRANT/ACCESS
    always_comb begin
        state_nxt  = state;
        sample     = 1'b0;
        load_rdata = 1'b0;
        set_err    = 1'b0;
        resp_data  = 16'h0000;
        case (state)
            ST_IDLE: begin
                if (cpu_req || ctr_req) begin
                    sample    = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (prot_hit) begin
                    load_rdata = 1'b1;
                    set_err    = 1'b1;
                    state_nxt  = ST_RESP;
                end else if (bank_hit) begin
                    load_rdata = 1'b1;
                    resp_data  = bank_read(eb, fb, sb, addr_lat);
                    state_nxt  = ST_RESP;
                end else begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    load_rdata = 1'b1;
                    resp_data  = mem_rdata;
                    state_nxt  = ST_RESP;
                end else if (tmr == 8'd1) begin
                    // last allowed cycle without ready: abort with zero data
                    load_rdata = 1'b1;
                    set_err    = 1'b1;
                    state_nxt  = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winning request when it is sampled in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_ctr <= 1'b0;
            we_lat    <= 1'b0;
            addr_lat  <= 12'h000;
            mem_wdata <= 16'h0000;
        end else if (sample) begin
            owner_ctr <= grant_ctr;
            we_lat    <= grant_ctr ? ctr_we    : cpu_we;
            addr_lat  <= grant_ctr ? ctr_addr  : cpu_addr;
            mem_wdata <= grant_ctr ? ctr_wdata : cpu_wdata;
        end
    end

    // Translate in GRANT and run the abort down-counter during ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= 16'h0000;
            tmr      <= 8'h00;
        end else if (state == ST_GRANT) begin
            mem_addr <= agc_translate(eb, fb, sb, addr_lat);
            tmr      <= TMO_LOAD;
        end else if ((state == ST_ACCESS) && !mem_ready) begin
            tmr <= tmr - 8'd1;
        end
    end

    // Response data for the owner and the err flag shown during RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= 16'h0000;
            ctr_rdata <= 16'h0000;
            err_flag  <= 1'b0;
        end else begin
            if (sample)  err_flag <= 1'b0;
            if (set_err) err_flag <= 1'b1;
            if (load_rdata) begin
                if (owner_ctr) ctr_rdata <= resp_data;
                else           cpu_rdata <= resp_data;
            end
        end
    end

    // Bank-register writes land in GRANT, after this request's translation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eb <= 3'b000;
            fb <= 5'b00000;
            sb <= 1'b0;
        end else if ((state == ST_GRANT) && bank_hit && we_lat && !prot_hit) begin
            case (addr_lat)
                EB_ADDR: eb <= mem_wdata[10:8];
                FB_ADDR: fb <= mem_wdata[14:10];
                BB_ADDR: begin
                    fb <= mem_wdata[14:10];
                    eb <= mem_wdata[2:0];
                end
                SB_ADDR: sb <= mem_wdata[6];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_agc_mem_sequencer.sv
`timescale 1ns/1ps
module tb_agc_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, ctr_req, ctr_we;
    logic [11:0] cpu_addr, ctr_addr;
    logic [15:0] cpu_wdata, ctr_wdata;
    logic        cpu_ack, ctr_ack;
    logic [15:0] cpu_rdata, ctr_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  eb_q;
    logic [4:0]  fb_q;
    logic        sb_q, err;

    int n_assert = 0;
    int n_fail   = 0;
    int err_stray = 0;

    int ready_delay = 0;
    bit ready_never = 1'b0;
    int acc_cyc     = 0;

    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] ref_mem [int];
    int eb_m = 0, fb_m = 0, sb_m = 0;
    bit rr_ctr = 1'b0;

    agc_mem_sequencer #(
        .TIMEOUT_CYC  (15),
        .CTR_FIXED_PRI(0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .ctr_req  (ctr_req),
        .ctr_we   (ctr_we),
        .ctr_addr (ctr_addr),
        .ctr_wdata(ctr_wdata),
        .ctr_ack  (ctr_ack),
        .ctr_rdata(ctr_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .eb_q     (eb_q),
        .fb_q     (fb_q),
        .sb_q     (sb_q),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 37 + 1443) % 65536);
    endfunction

    function automatic logic [15:0] rd_mem(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_val(int'(a));
    endfunction

    function automatic logic [15:0] ref_mem_read(input int p);
        if (ref_mem.exists(p)) return ref_mem[p];
        return init_val(p);
    endfunction

    // Reference translation: 1K pages, erasable sub-page 3 banked by EB
    function automatic int ref_phys(input int a);
        int page, off;
        page = a / 1024;
        off  = a % 1024;
        if (page == 0) begin
            if (off / 256 == 3) return eb_m * 256 + off % 256;
            return off;
        end
        if (page == 1) begin
            if (fb_m / 8 == 3 && sb_m == 1) return 32768 + (fb_m % 8) * 1024 + off;
            return fb_m * 1024 + off;
        end
        return a;
    endfunction

    function automatic int ref_bank_read(input int a);
        case (a)
            3: return eb_m * 256;
            4: return fb_m * 1024;
            6: return fb_m * 1024 + eb_m;
            7: return sb_m * 64;
            default: return 0;
        endcase
    endfunction

    task automatic ref_bank_write(input int a, input int d);
        case (a)
            3: eb_m = (d / 256) % 8;
            4: fb_m = (d / 1024) % 32;
            6: begin fb_m = (d / 1024) % 32; eb_m = d % 8; end
            7: sb_m = (d / 64) % 2;
            default: ;
        endcase
    endtask

    // Memory model: ready after ready_delay ACCESS cycles; random noise elsewhere
    always @(negedge clk) begin
        if (mem_en) begin
            if (!ready_never && acc_cyc == ready_delay) begin
                mem_ready = 1'b1;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                mem_rdata = rd_mem(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
            end
            acc_cyc++;
        end else begin
            mem_ready = 1'($urandom & 1);
            mem_rdata = 16'($urandom);
            acc_cyc   = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_ctl", tag), 32'({cpu_ack, ctr_ack, mem_en, mem_we, err}), 32'd0);
        check($sformatf("%s_rdata", tag), {cpu_rdata, ctr_rdata}, 32'd0);
        check($sformatf("%s_mem", tag), {mem_addr, mem_wdata}, 32'd0);
        check($sformatf("%s_banks", tag), 32'({eb_q, fb_q, sb_q}), 32'd0);
    endtask

    // One request from one requester; lat counts cycles from the sampling edge
    task automatic xact(input bit who_ctr, input bit we, input logic [11:0] addr,
                        input logic [15:0] wdata, input int dly,
                        output logic [15:0] rdata, output bit err_o, output int lat,
                        output logic [15:0] maddr, output bit saw_en, output bit saw_we);
        bit done;
        rdata = '0; err_o = 1'b0; lat = 0; maddr = '0;
        saw_en = 1'b0; saw_we = 1'b0; done = 1'b0;
        ready_delay = dly;
        @(posedge clk); #1;
        if (who_ctr) begin
            ctr_req = 1'b1; ctr_we = we; ctr_addr = addr; ctr_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        @(posedge clk);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (mem_en) begin
                saw_en = 1'b1;
                maddr  = mem_addr;
                if (mem_we) saw_we = 1'b1;
            end
            if (who_ctr ? ctr_ack : cpu_ack) begin
                done  = 1'b1;
                lat   = c;
                rdata = who_ctr ? ctr_rdata : cpu_rdata;
                err_o = err;
                if (who_ctr ? cpu_ack : ctr_ack) err_stray++;
            end else if (err || cpu_ack || ctr_ack) begin
                err_stray++;
            end
        end
        cpu_req = 1'b0;
        ctr_req = 1'b0;
        check("ack_seen", 32'(done), 32'd1);
        rr_ctr = !who_ctr;
    endtask

    // Request plus all model-based checks and model update
    task automatic run_xact(input bit who_ctr, input bit we, input logic [11:0] addr,
                            input logic [15:0] wdata, input int dly,
                            output logic [15:0] rd, output logic [15:0] ma);
        bit e, sen, swe, is_bank, prot;
        int lat, exp_phys;
        logic [15:0] exp_rd;
        is_bank = (addr == 12'o3) || (addr == 12'o4) || (addr == 12'o6) || (addr == 12'o7);
        prot = 1'b0;
`ifdef FIXED_WRITE_PROTECT_EN
        prot = we && (int'(addr) / 1024 != 0);
`endif
        exp_phys = ref_phys(int'(addr));
        exp_rd   = is_bank ? 16'(ref_bank_read(int'(addr))) : ref_mem_read(exp_phys);
        xact(who_ctr, we, addr, wdata, dly, rd, e, lat, ma, sen, swe);
        if (is_bank || prot) begin
            check("reg_lat", 32'(lat), 32'd2);
            check("reg_no_mem", 32'({sen, swe}), 32'd0);
        end else begin
            check("mem_lat", 32'(lat), 32'(3 + dly));
            check("mem_addr", 32'(ma), 32'(exp_phys));
            check("mem_we", 32'(swe), 32'(we));
        end
        check("err", 32'(e), 32'(prot));
        if (!we) check("rdata", 32'(rd), 32'(exp_rd));
        if (we && is_bank)    ref_bank_write(int'(addr), int'(wdata));
        else if (we && !prot) ref_mem[exp_phys] = wdata;
        check("banks", 32'({eb_q, fb_q, sb_q}), 32'(eb_m * 64 + fb_m * 2 + sb_m));
    endtask

    initial begin
        logic [15:0] rd, ma, wd;
        logic [11:0] a;
        bit e, sen, swe, we, who, seen;
        int lat, nack, ovl, acks, cat;
        int order [4];

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ctr_req = 1'b0; ctr_we = 1'b0; ctr_addr = '0; ctr_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Superbank read
        run_xact(1'b0, 1'b1, 12'o4, 16'h6000, 0, rd, ma);
        check("fb_lit", 32'(fb_q), 32'h18);
        run_xact(1'b0, 1'b1, 12'o7, 16'h0040, 0, rd, ma);
        check("sb_lit", 32'(sb_q), 32'd1);
        mem_arr[16'h8100] = 16'h1234;
        ref_mem[32'h8100] = 16'h1234;
        run_xact(1'b0, 1'b0, 12'h500, 16'h0000, 0, rd, ma);
        check("sb_maddr_lit", 32'(ma), 32'h8100);
        check("sb_rdata_lit", 32'(rd), 32'h1234);
        repeat (3) @(negedge clk);
        check("rdata_hold", 32'(cpu_rdata), 32'h1234);

        // Erasable bank
        run_xact(1'b0, 1'b1, 12'o3, 16'h0500, 0, rd, ma);
        check("eb_lit", 32'(eb_q), 32'd5);
        run_xact(1'b0, 1'b0, 12'h345, 16'h0000, 1, rd, ma);
        check("eb_maddr_lit", 32'(ma), 32'h0545);
        run_xact(1'b1, 1'b0, 12'h2AA, 16'h0000, 2, rd, ma);
        check("fixed0_maddr_lit", 32'(ma), 32'h02AA);
        run_xact(1'b1, 1'b0, 12'o6, 16'h0000, 0, rd, ma);
        check("bb_read_lit", 32'(rd), 32'h6005);

        // Contention: both held high, grants alternate, acks never overlap
        ready_delay = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h800;
        ctr_req = 1'b1; ctr_we = 1'b0; ctr_addr = 12'hC10;
        nack = 0; ovl = 0;
        for (int k = 0; k < 4; k++) order[k] = 2;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(negedge clk);
            if (cpu_ack && ctr_ack) ovl++;
            if (cpu_ack) check("cont_cpu_rdata", 32'(cpu_rdata), 32'(ref_mem_read(32'h800)));
            if (ctr_ack) check("cont_ctr_rdata", 32'(ctr_rdata), 32'(ref_mem_read(32'hC10)));
            if (cpu_ack || ctr_ack) begin
                order[nack] = ctr_ack ? 1 : 0;
                nack++;
            end
        end
        cpu_req = 1'b0; ctr_req = 1'b0;
        check("cont_nack", 32'(nack), 32'd4);
        check("cont_overlap", 32'(ovl), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cont_grant%0d", k), 32'(order[k]), 32'(rr_ctr));
            rr_ctr = !rr_ctr;
        end

        // Timeout: 15 ACCESS cycles then aborted ack with err and zero data
        ready_never = 1'b1;
        xact(1'b0, 1'b0, 12'h900, 16'h0000, 0, rd, e, lat, ma, sen, swe);
        ready_never = 1'b0;
        check("tmo_lat", 32'(lat), 32'd17);
        check("tmo_err", 32'(e), 32'd1);
        check("tmo_rdata", 32'(rd), 32'd0);
        check("tmo_maddr", 32'(ma), 32'h0900);

        // Fixed-memory write (refused when write protect is built in)
        run_xact(1'b0, 1'b1, 12'hC00, 16'h55AA, 0, rd, ma);
        run_xact(1'b1, 1'b0, 12'hC00, 16'h0000, 0, rd, ma);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            cat = $urandom_range(0, 5);
            case (cat)
                0: begin
                    case ($urandom_range(0, 3))
                        0: a = 12'o3;
                        1: a = 12'o4;
                        2: a = 12'o6;
                        default: a = 12'o7;
                    endcase
                end
                1: a = 12'($urandom_range(0, 767));
                2: a = 12'(768 + $urandom_range(0, 255));
                3: a = 12'(1024 + $urandom_range(0, 1023));
                default: a = 12'(2048 + $urandom_range(0, 2047));
            endcase
            we  = 1'($urandom_range(0, 1));
            who = 1'($urandom_range(0, 1));
            wd  = 16'($urandom);
            run_xact(who, we, a, wd, $urandom_range(0, 3), rd, ma);
        end

        check("stray_ack_err", 32'(err_stray), 32'd0);

        // Reset in the middle of a memory access
        run_xact(1'b0, 1'b1, 12'o6, 16'hFFFF, 0, rd, ma);
        ready_never = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 16'hBEEF;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) seen = 1'b1;
        end
        check("mid_en_seen", 32'(seen), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack || ctr_ack || err) acks++;
        end
        check("no_ack_after_rst", 32'(acks), 32'd0);
        ready_never = 1'b0;
        eb_m = 0; fb_m = 0; sb_m = 0; rr_ctr = 1'b0;
        run_xact(1'b0, 1'b0, 12'o6, 16'h0000, 0, rd, ma);
        check("post_rst_bb", 32'(rd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/agc_mem_sequencer.md
Name: agc_mem_sequencer

Overview:
- Owns the bank registers (EB, FB, superbank) and shares the single memory port between two requesters: CPU and the counter/involuntary-increment unit.
- Per request: arbitrates, translates the 12-bit logical address to a 16-bit physical address, runs the memory handshake, and returns read data and ack.
- Sits between the CPU/counter units and the memory array wrapper.

Parameters:
- TIMEOUT_CYC, 15, ACCESS cycles allowed before abort (1..255).
- CTR_FIXED_PRI, 0, 1 = counter always wins contention; 0 = round-robin.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req/ctr_req  in  1  request, held until ack
- cpu_we/ctr_we  in  1  1 = write
- cpu_addr/ctr_addr  in  12  logical address
- cpu_wdata/ctr_wdata  in  16  write data
- cpu_ack/ctr_ack  out  1  one-cycle completion pulse
- cpu_rdata/ctr_rdata  out  16  read data, valid in the ack cycle, held until the next ack to that requester
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  16  physical address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory completes when high while mem_en is high
- eb_q  out  3  erasable bank
- fb_q  out  5  fixed bank
- sb_q  out  1  superbank bit
- err  out  1  one-cycle pulse on timeout or protection violation

Behaviour:
- Reset, asynchronous: every output 0, all bank registers 0, state IDLE, round-robin pointer favours CPU.
- FSM states: IDLE, GRANT, ACCESS, RESP.
- IDLE: sample the requests. If any is high, latch the winner's we/addr/wdata and go to GRANT.
- Round-robin contention: the winner alternates; the pointer updates only on a grant.
- GRANT: compute the translated address into mem_addr.
- Bank-register address targets, no memory cycle, go to RESP:
  - 12'o3: eb = wdata[10:8].
  - 12'o4: fb = wdata[14:10].
  - 12'o6: fb = wdata[14:10] and eb = wdata[2:0].
  - 12'o7: sb = wdata[6].
  - Reads of these addresses return the value in the same bit positions, zeros elsewhere.
  - 12'o6 read returns both fields.
- Otherwise go to ACCESS.
- Translation, decided rule:
  - addr[11:10]=00 and addr[9:8]=11: {5'b0,eb,addr[7:0]}.
  - addr[11:10]=00 otherwise: {6'b0,addr[9:0]}.
  - addr[11:10]=01 and fb[4:3]=11 and sb=1: {3'b100,fb[2:0],addr[9:0]}.
  - addr[11:10]=01 otherwise: {1'b0,fb,addr[9:0]}.
  - addr[11:10]=1x: {4'b0,addr}.
- Translation uses the bank values current in GRANT. A bank write takes effect for the next request.
- ACCESS:
  - mem_en=1, mem_we=latched we, mem_wdata=latched wdata.
  - On mem_ready=1: capture mem_rdata, go to RESP.
  - The timeout counter increments each ACCESS cycle. On reaching TIMEOUT_CYC: abort, rdata=0, err pulse in RESP.
- RESP: mem_en=0; winner's ack=1 for one cycle; return to IDLE.
- Latency:
  - Register access: ack 2 cycles after req is sampled.
  - Memory access: ack 3 cycles after sampling when mem_ready is high in the first ACCESS cycle.
- A new request is sampled only in IDLE, so there is at most one outstanding request.
- A req dropped before ack is a protocol error; the latched request still completes.
- mem_ready outside ACCESS is ignored.
- Reset mid-access aborts immediately; no ack is issued.

Optional Feature:
- Macro FIXED_WRITE_PROTECT_EN.
- Defined: a write to addr[11:10]!=00 skips ACCESS, mem_we is never asserted, RESP acks with err=1.
- Undefined: fixed-memory writes run a normal memory cycle; err reflects only timeouts.

Decomposition:
- Package agc_mem_pkg holds:
  - State enum.
  - Bank-register address constants (EB_ADDR=12'o3, FB_ADDR=12'o4, BB_ADDR=12'o6, SB_ADDR=12'o7).
  - Translation function taking (eb, fb, sb, addr).
- One sub-module: agc_rr_arb, the 2-way arbiter with pointer and fixed-priority option.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS -> all outputs 0, eb_q/fb_q/sb_q=0, no ack after release.
- Superbank read:
  - CPU write 12'o4 with 16'h6000 -> fb_q=5'b11000.
  - Write 12'o7 with 16'h0040 -> sb_q=1.
  - CPU read 12'h500 -> mem_addr=16'h8100.
  - mem_rdata 16'h1234 -> cpu_rdata=16'h1234 in the cpu_ack cycle.
- Erasable bank: write 12'o3 with 16'h0500 -> eb_q=3'b101; read 12'h345 -> mem_addr=16'h0545; read 12'h2AA -> mem_addr=16'h02AA.
- Contention, CTR_FIXED_PRI=0: both req high continuously -> grants alternate CPU, CTR, CPU, CTR; acks never overlap.
- Timeout: mem_ready tied 0, TIMEOUT_CYC=15 -> ack with rdata=0 and err=1 after 15 ACCESS cycles.
- FIXED_WRITE_PROTECT_EN defined: CPU write 12'hC00 -> mem_we stays 0, cpu_ack=1 with err=1.
